// File: rtl/spi_window_receiver.sv
// rtl/spi_window_receiver.sv - SPI column receiver building a sliding ROWSxCOLS pixel window
module spi_window_receiver #(
  parameter int PIXEL_BITS = 4,
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int FRAME_BITS = 16,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                                mainClk,
  input  logic                                nreset,
  input  logic                                spiClk,
  input  logic                                sdi,
  input  logic                                ncs,
  output logic [ROWS*COLS*PIXEL_BITS-1:0]     pixelWindow,
  output logic                                windowValid,
  input  logic                                windowReady,
  output logic [$clog2(IMG_WIDTH)-1:0]        spiXVal,
  output logic [$clog2(IMG_HEIGHT)-1:0]       spiYVal,
  output logic                                overrun,
  output logic                                frameDone
);

  localparam int CW = ROWS * PIXEL_BITS;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int FW = $clog2(COLS + 1);

  localparam logic [XW-1:0] XMAX     = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMAX     = YW'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [FW-1:0] FULL     = FW'(COLS);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT    = 2'd1;
  localparam logic [1:0] ST_COMPLETE = 2'd2;

  logic [1:0]            sclkSync, sdiSync, ncsSync;
  logic                  sclkDly, ncsDly;
  logic                  armed;
  logic [FRAME_BITS-1:0] shiftReg;
  logic [BW-1:0]         bitCount;
  logic [1:0]            state;
  logic [CW-1:0]         colStore [COLS];
  logic [XW-1:0]         nextX;
  logic [YW-1:0]         nextY;
  logic [FW-1:0]         colFill;

  logic                  sclkRise, ncsRise;
  logic                  accept, drop;
  logic                  lineEnd, frameEnd;
  logic [FW-1:0]         fillNext;
  logic                  unusedPad;

  assign sclkRise = sclkSync[1] & ~sclkDly;
  assign ncsRise  = ncsSync[1] & ~ncsDly;

  // A finished word is dropped only when the previous window is still pending
  assign drop     = (state == ST_COMPLETE) && windowValid && !windowReady;
  assign accept   = (state == ST_COMPLETE) && !(windowValid && !windowReady);
  assign lineEnd  = (nextX == XMAX);
  assign frameEnd = lineEnd && (nextY == YMAX);
  assign fillNext = (nextX == '0) ? FW'(1) :
                    ((colFill >= FULL) ? FULL : colFill + FW'(1));

  // The top shift bit falls off the register and is padding anyway
  assign unusedPad = shiftReg[FRAME_BITS-1];

  // Synchronize the SPI pins and keep one-cycle-old copies for edge detection
  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      sclkSync <= '0;
      sdiSync  <= '0;
      ncsSync  <= '0;
      sclkDly  <= 1'b0;
      ncsDly   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[0], spiClk};
      sdiSync  <= {sdiSync[0], sdi};
      ncsSync  <= {ncsSync[0], ncs};
      sclkDly  <= sclkSync[1];
      ncsDly   <= ncsSync[1];
      // a transfer already running at reset release is skipped until ncs idles high
      armed    <= armed | ncsSync[1];
    end
  end

  // Receiver FSM: shift bits while selected, flag a complete word for one cycle
  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      shiftReg <= '0;
      bitCount <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bitCount <= '0;
          if (armed && !ncsSync[1]) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (ncsRise) begin
            state    <= ST_IDLE;
            bitCount <= '0;
          end else if (sclkRise) begin
            shiftReg <= {shiftReg[FRAME_BITS-2:0], sdiSync[1]};
            if (bitCount == LAST_BIT) begin
              bitCount <= '0;
              state    <= ST_COMPLETE;
            end else begin
              bitCount <= bitCount + BW'(1);
            end
          end
        end
        ST_COMPLETE: begin
          state <= ncsSync[1] ? ST_IDLE : ST_SHIFT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Column store, coordinates, window handshake and status flags
  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      for (int c = 0; c < COLS; c++) colStore[c] <= '0;
      nextX       <= '0;
      nextY       <= '0;
      spiXVal     <= '0;
      spiYVal     <= '0;
      colFill     <= '0;
      windowValid <= 1'b0;
      overrun     <= 1'b0;
      frameDone   <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      if (accept) begin
        for (int c = 0; c < COLS - 1; c++) colStore[c] <= colStore[c+1];
        colStore[COLS-1] <= shiftReg[CW-1:0];
        spiXVal <= nextX;
        spiYVal <= nextY;
        nextX   <= lineEnd ? '0 : nextX + XW'(1);
        if (lineEnd) nextY <= frameEnd ? '0 : nextY + YW'(1);
        colFill     <= fillNext;
        // windows that would straddle a line boundary are never presented
        windowValid <= (fillNext >= FULL);
        frameDone   <= frameEnd;
      end else if (windowValid && windowReady) begin
        windowValid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  // Present the store as [row][col]; row 0 is the most significant pixel of a column word
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign pixelWindow[(r*COLS+c)*PIXEL_BITS +: PIXEL_BITS] =
        colStore[c][(ROWS-1-r)*PIXEL_BITS +: PIXEL_BITS];
    end
  end

endmodule

// File: tb/tb_spi_window_receiver.sv
// tb/tb_spi_window_receiver.sv - self-checking bench for spi_window_receiver
module tb_spi_window_receiver;

  logic mainClk = 1'b0;
  logic nreset = 1'b0;
  logic spiClk = 1'b0;
  logic sdi = 1'b0;
  logic ncs = 1'b1;
  logic windowReady = 1'b0;

  logic [35:0] pw, pwS;
  logic        wv, wvS, ov, ovS, fd, fdS;
  logic [9:0]  sx;
  logic [8:0]  sy;
  logic [1:0]  sxS;
  logic [0:0]  syS;

  int errors = 0;
  int checks = 0;

  always #5 mainClk = ~mainClk;

  spi_window_receiver dut (
    .mainClk(mainClk), .nreset(nreset), .spiClk(spiClk), .sdi(sdi), .ncs(ncs),
    .pixelWindow(pw), .windowValid(wv), .windowReady(windowReady),
    .spiXVal(sx), .spiYVal(sy), .overrun(ov), .frameDone(fd)
  );

  spi_window_receiver #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) dutS (
    .mainClk(mainClk), .nreset(nreset), .spiClk(spiClk), .sdi(sdi), .ncs(ncs),
    .pixelWindow(pwS), .windowValid(wvS), .windowReady(windowReady),
    .spiXVal(sxS), .spiYVal(syS), .overrun(ovS), .frameDone(fdS)
  );

  // Event monitors sampled on the falling edge
  int   rises = 0, risesS = 0, fdCountS = 0;
  logic prevV = 1'b0, prevVS = 1'b0;
  always @(negedge mainClk) begin
    if (wv && !prevV) rises++;
    if (wvS && !prevVS) risesS++;
    if (fdS) fdCountS++;
    prevV  = wv;
    prevVS = wvS;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge mainClk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input bit raise);
    ncs = 1'b0;
    cyc(3);
    for (int i = 0; i < n; i++) begin
      sdi = w[15-i];
      cyc(3);
      spiClk = 1'b1;
      cyc(3);
      spiClk = 1'b0;
    end
    cyc(3);
    if (raise) begin
      ncs = 1'b1;
      cyc(4);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits(w, 16, 1'b1);
  endtask

  // Expected window from three column words, oldest first
  function automatic logic [35:0] win(input logic [11:0] c0, input logic [11:0] c1,
                                      input logic [11:0] c2);
    logic [11:0] col [3];
    logic [35:0] res;
    col[0] = c0; col[1] = c1; col[2] = c2;
    res = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        res[(r*3+c)*4 +: 4] = col[c][(2-r)*4 +: 4];
    return res;
  endfunction

  task automatic test_reset;
    nreset = 1'b0; ncs = 1'b1;
    cyc(3);
    checks++; if (pw !== 36'h0) begin errors++; $display("FAIL reset_window: got %h want 0", pw); end
    checks++; if (wv !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", wv); end
    checks++; if (sx !== 10'd0 || sy !== 9'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", sx, sy); end
    checks++; if (ov !== 1'b0 || fd !== 1'b0) begin errors++; $display("FAIL reset_flags: got ov=%b fd=%b want 0,0", ov, fd); end
    nreset = 1'b1;
    cyc(4);
  endtask

  task automatic test_first_window;
    int base;
    windowReady = 1'b1;
    base = rises;
    send_word(16'h0123);
    checks++; if (rises - base !== 0) begin errors++; $display("FAIL first_w1_valid: got %0d rises want 0", rises - base); end
    send_word(16'h0456);
    checks++; if (rises - base !== 0) begin errors++; $display("FAIL first_w2_valid: got %0d rises want 0", rises - base); end
    send_word(16'h0789);
    checks++; if (rises - base !== 1) begin errors++; $display("FAIL first_w3_valid: got %0d rises want 1", rises - base); end
    checks++; if (pw !== 36'h963852741) begin errors++; $display("FAIL first_window: got %h want 963852741", pw); end
    checks++; if (sx !== 10'd2 || sy !== 9'd0) begin errors++; $display("FAIL first_xy: got %0d,%0d want 2,0", sx, sy); end
    checks++; if (wv !== 1'b0) begin errors++; $display("FAIL first_consumed: got %b want 0", wv); end
  endtask

  task automatic test_fourth_word;
    windowReady = 1'b0;
    send_word(16'h0ABC);
    checks++; if (wv !== 1'b1) begin errors++; $display("FAIL fourth_valid: got %b want 1", wv); end
    checks++; if ({pw[11:8], pw[7:4], pw[3:0]} !== 12'hA74) begin errors++; $display("FAIL fourth_row0: got %h want a74", {pw[11:8], pw[7:4], pw[3:0]}); end
    checks++; if (pw !== win(12'h456, 12'h789, 12'hABC)) begin errors++; $display("FAIL fourth_window: got %h want %h", pw, win(12'h456, 12'h789, 12'hABC)); end
    checks++; if (sx !== 10'd3) begin errors++; $display("FAIL fourth_x: got %0d want 3", sx); end
    cyc(20);
    checks++; if (wv !== 1'b1 || sx !== 10'd3 || pw !== win(12'h456, 12'h789, 12'hABC)) begin errors++; $display("FAIL fourth_hold: got v=%b x=%0d w=%h want held", wv, sx, pw); end
    windowReady = 1'b1;
    cyc(1);
    windowReady = 1'b0;
    cyc(2);
    checks++; if (wv !== 1'b0) begin errors++; $display("FAIL fourth_release: got %b want 0", wv); end
  endtask

  task automatic test_overrun;
    windowReady = 1'b0;
    send_word(16'h0D1E);
    checks++; if (wv !== 1'b1 || sx !== 10'd4) begin errors++; $display("FAIL ovr_first: got v=%b x=%0d want 1,4", wv, sx); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", ov); end
    send_word(16'h0222);
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", ov); end
    checks++; if (pw !== win(12'h789, 12'hABC, 12'hD1E) || sx !== 10'd4) begin errors++; $display("FAIL ovr_unchanged: got %h x=%0d want %h x=4", pw, sx, win(12'h789, 12'hABC, 12'hD1E)); end
    windowReady = 1'b1;
    cyc(2);
    checks++; if (wv !== 1'b0 || ov !== 1'b1) begin errors++; $display("FAIL ovr_release: got v=%b ov=%b want 0,1", wv, ov); end
  endtask

  task automatic test_abort;
    windowReady = 1'b1;
    send_bits(16'h0333, 9, 1'b1);
    send_word(16'h0FFF);
    checks++; if (pw !== win(12'hABC, 12'hD1E, 12'hFFF)) begin errors++; $display("FAIL abort_window: got %h want %h", pw, win(12'hABC, 12'hD1E, 12'hFFF)); end
    checks++; if (sx !== 10'd5 || sy !== 9'd0) begin errors++; $display("FAIL abort_xy: got %0d,%0d want 5,0", sx, sy); end
  endtask

  task automatic test_wrap;
    int bv, fb;
    nreset = 1'b0; ncs = 1'b1;
    cyc(2);
    nreset = 1'b1;
    cyc(4);
    windowReady = 1'b1;
    fb = fdCountS;
    for (int k = 0; k < 8; k++) begin
      bv = risesS;
      send_word(16'($urandom));
      checks++; if (sxS !== 2'(k % 4) || syS !== 1'(k / 4)) begin errors++; $display("FAIL wrap_xy%0d: got %0d,%0d want %0d,%0d", k, sxS, syS, k % 4, k / 4); end
      checks++; if (risesS - bv !== ((k % 4) >= 2 ? 1 : 0)) begin errors++; $display("FAIL wrap_valid%0d: got %0d want %0d", k, risesS - bv, (k % 4) >= 2 ? 1 : 0); end
      checks++; if (fdCountS - fb !== (k == 7 ? 1 : 0)) begin errors++; $display("FAIL wrap_frame%0d: got %0d want %0d", k, fdCountS - fb, k == 7 ? 1 : 0); end
    end
    send_word(16'($urandom));
    checks++; if (sxS !== 2'd0 || syS !== 1'd0) begin errors++; $display("FAIL wrap_next_xy: got %0d,%0d want 0,0", sxS, syS); end
    checks++; if (fdCountS - fb !== 1) begin errors++; $display("FAIL wrap_frame_once: got %0d want 1", fdCountS - fb); end
  endtask

  task automatic test_midreset;
    windowReady = 1'b1;
    send_bits(16'h0777, 7, 1'b0);
    nreset = 1'b0;
    cyc(2);
    checks++; if (pw !== 36'h0 || wv !== 1'b0 || sx !== 10'd0 || sy !== 9'd0 || ov !== 1'b0 || fd !== 1'b0) begin errors++; $display("FAIL midreset_zero: got w=%h v=%b xy=%0d,%0d ov=%b fd=%b want all 0", pw, wv, sx, sy, ov, fd); end
    nreset = 1'b1;
    send_bits(16'h0777 << 7, 9, 1'b1);
    checks++; if (pw !== 36'h0 || sx !== 10'd0) begin errors++; $display("FAIL midreset_ignored: got w=%h x=%0d want 0,0", pw, sx); end
    send_word(16'h0CAB);
    checks++; if (pw !== win(12'h0, 12'h0, 12'hCAB) || sx !== 10'd0 || sy !== 9'd0 || wv !== 1'b0) begin errors++; $display("FAIL midreset_col0: got w=%h xy=%0d,%0d v=%b want %h 0,0 0", pw, sx, sy, wv, win(12'h0, 12'h0, 12'hCAB)); end
  endtask

  // Random words and consumer behaviour against a queue model of accepted columns
  task automatic test_random;
    logic [11:0] store [$];
    logic [15:0] w;
    int   k, lx, ly;
    bit   mvalid, movr;
    store = '{12'h0, 12'h0, 12'hCAB};
    k = 1; lx = 0; ly = 0; mvalid = 1'b0; movr = 1'b0;
    for (int it = 0; it < 30; it++) begin
      windowReady = 1'b0;
      w = 16'($urandom);
      send_word(w);
      if (mvalid) begin
        movr = 1'b1;
      end else begin
        store.push_back(w[11:0]);
        void'(store.pop_front());
        lx = k % 640;
        ly = (k / 640) % 480;
        k++;
        mvalid = (lx >= 2);
      end
      checks++; if (wv !== mvalid || ov !== movr) begin errors++; $display("FAIL rand_flags%0d: got v=%b ov=%b want %b,%b", it, wv, ov, mvalid, movr); end
      if (mvalid) begin
        checks++; if (pw !== win(store[0], store[1], store[2]) || sx !== 10'(lx) || sy !== 9'(ly)) begin errors++; $display("FAIL rand_window%0d: got %h %0d,%0d want %h %0d,%0d", it, pw, sx, sy, win(store[0], store[1], store[2]), lx, ly); end
      end
      if ($urandom_range(1, 0) == 1) begin
        windowReady = 1'b1;
        cyc(1);
        windowReady = 1'b0;
        cyc(2);
        mvalid = 1'b0;
        checks++; if (wv !== 1'b0) begin errors++; $display("FAIL rand_consume%0d: got %b want 0", it, wv); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_fourth_word();
    test_overrun();
    test_abort();
    test_wrap();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
